// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide, 32 iterations per operation.
//
// state | meaning
// IDLE  | waiting for Start; StallReq follows Start & ~Flush
// CALC  | one multiplier/quotient bit per cycle, pipeline frozen
// DONE  | MdOut just written, Done high for this cycle only
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [2:0]  MdOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  input  logic        Flush,
  output logic        StallReq,
  output logic        Done,
  output logic [31:0] MdOut
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic        div0;

  logic        signed_a;
  logic        signed_b;
  logic        neg_a;
  logic        neg_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_nxt;
  logic [63:0] acc_nxt;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] result;

  assign signed_a = (MdOp == 3'd1) || (MdOp == 3'd2) || (MdOp == 3'd4) || (MdOp == 3'd6);
  assign signed_b = (MdOp == 3'd1) || (MdOp == 3'd4) || (MdOp == 3'd6);
  assign neg_a    = signed_a & Operand1[31];
  assign neg_b    = signed_b & Operand2[31];

  assign StallReq = (Start && (state == IDLE) && !Flush) || (state == CALC);

  // multiply: multiplier in b_q shifts out LSB first, product enters from the top
  assign mul_sum = {1'b0, acc[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};

  // divide: dividend in a_q shifts out MSB first; acc = {remainder, quotient}
  assign div_shift = {acc[63:32], a_q[31]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_nxt   = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0], acc[30:0], 1'b1};

  assign acc_nxt = op_q[2] ? div_nxt : mul_nxt;

  // zero divisor yields all-ones quotient; remainder naturally restores to the dividend
  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign quo  = div0 ? 32'hFFFF_FFFF : (neg_q ? -acc_nxt[31:0] : acc_nxt[31:0]);
  assign rem  = neg_r ? -acc_nxt[63:32] : acc_nxt[63:32];

  always_comb begin
    result = 32'd0;
    case (op_q)
      3'd0:                result = prod[31:0];
      3'd1, 3'd2, 3'd3:    result = prod[63:32];
      3'd4, 3'd5:          result = quo;
      default:             result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      acc   <= 64'd0;
      cnt   <= 5'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
      Done  <= 1'b0;
      MdOut <= 32'd0;
    end else if (Flush) begin
      state <= IDLE;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_q  <= MdOp;
            a_q   <= neg_a ? -Operand1 : Operand1;
            b_q   <= neg_b ? -Operand2 : Operand2;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            div0  <= (Operand2 == 32'd0);
            acc   <= 64'd0;
            cnt   <= 5'd0;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          if (op_q[2]) a_q <= {a_q[30:0], 1'b0};
          else         b_q <= {1'b0, b_q[31:1]};
          if (cnt == 5'd31) begin
            MdOut <= result;
            Done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus cycle-level timing
// expectations, checked every cycle, with directed literal-result vectors.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic [2:0]  MdOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic        Flush;
  logic        StallReq;
  logic        Done;
  logic [31:0] MdOut;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit run_chk = 0;

  // timing model: busy from the accepted Start cycle s_cyc until the Done cycle s_cyc+33
  bit          busy = 0;
  int          s_cyc = 0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] held = 32'd0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MdOp(MdOp),
    .Operand1(Operand1), .Operand2(Operand2), .Flush(Flush),
    .StallReq(StallReq), .Done(Done), .MdOut(MdOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      ub;
    int          x;
    int          y;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    x  = $signed(a);
    y  = $signed(b);
    p  = 64'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return x / y;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return x % y;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // per-cycle compare against the model, then advance the model for the next cycle
  always @(negedge clk) begin
    if (rst_n && run_chk) begin
      int  k;
      bit  exp_stall;
      bit  exp_done;
      k = cyc - s_cyc;
      exp_stall = (!busy && Start && !Flush) || (busy && k <= 32);
      exp_done  = busy && (k == 33);
      chk("stallreq", {31'd0, StallReq}, {31'd0, exp_stall});
      chk("done", {31'd0, Done}, {31'd0, exp_done});
      chk("mdout", MdOut, exp_done ? exp_res : held);
      if (exp_done) held = exp_res;
      if (Flush) busy = 0;
      else if (exp_done) busy = 0;
      else if (!busy && Start) begin
        busy    = 1;
        s_cyc   = cyc;
        exp_res = ref_md(MdOp, Operand1, Operand2);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input logic [31:0] lit);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: Done never seen, expected result 0x%08h", name, lit);
    end else begin
      chk(name, MdOut, lit);
    end
    tick();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MdOp = op;
    Operand1 = a;
    Operand2 = b;
    tick();
    Start = 1'b0;
    MdOp = 3'($urandom_range(7));
    Operand1 = $urandom;
    Operand2 = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
    issue(op, a, b);
    wait_done(name, lit);
  endtask

  initial begin
    rst_n = 1'b0;
    Start = 1'b0;
    MdOp = 3'd0;
    Operand1 = 32'd0;
    Operand2 = 32'd0;
    Flush = 1'b0;
    #2;
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_mdout", MdOut, 32'd0);
    chk("rst_stall", {31'd0, StallReq}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_chk = 1;
    tick();

    run_op("mul_7x6",     3'd0, 32'd7,          32'd6,          32'h0000_002A);
    run_op("mulh_m1m1",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000);
    run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF);
    run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run_op("div_by0",     3'd4, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF);
    run_op("rem_by0",     3'd6, 32'h1234_5678,  32'd0,          32'h1234_5678);
    run_op("rem_by0_neg", 3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);
    run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000);
    run_op("mul_neg",     3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1);
    run_op("divu_big",    3'd5, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC);

    // flush at CALC cycle 10 of a DIVU: no Done, MdOut keeps 0x7FFFFFFC
    issue(3'd5, 32'd1000, 32'd7);
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", {31'd0, StallReq}, 32'd0);
    chk("flush_hold", MdOut, 32'h7FFF_FFFC);
    tick();
    run_op("after_flush", 3'd5, 32'd1000, 32'd7, 32'd142);

    // Start together with Flush in IDLE is dropped
    Start = 1'b1;
    Flush = 1'b1;
    MdOp = 3'd0;
    Operand1 = 32'd3;
    Operand2 = 32'd3;
    tick();
    Start = 1'b0;
    Flush = 1'b0;
    repeat (40) tick();

    // Start while busy is ignored
    issue(3'd7, 32'd100, 32'd9);
    repeat (5) tick();
    Start = 1'b1;
    MdOp = 3'd0;
    Operand1 = 32'd11;
    Operand2 = 32'd13;
    tick();
    Start = 1'b0;
    wait_done("remu_busy_start", 32'd1);

    // asynchronous reset mid-CALC, between clock edges
    issue(3'd0, 32'd9, 32'd9);
    repeat (10) tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_done", {31'd0, Done}, 32'd0);
    chk("arst_mdout", MdOut, 32'd0);
    chk("arst_stall", {31'd0, StallReq}, 32'd0);
    busy = 0;
    held = 32'd0;
    #1;
    rst_n = 1'b1;
    tick();
    repeat (40) tick();
    run_op("post_reset", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. It takes the same forwarded Operand1/Operand2 pair for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU instructions and computes the result over 32 iterations. It holds a stall request so the hazard unit freezes IF/ID/EX while it works. It then presents a one-cycle-valid result for the EX/MEM segment register to capture.

## Interface
- No parameters. Data width is fixed at 32; the iteration count is fixed at 32.
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- Start  input  1  EX holds an M-extension instruction; sampled only in IDLE
- MdOp  input  3  operation, encoded as instruction funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- Operand1  input  32  rs1 value (multiplicand / dividend)
- Operand2  input  32  rs2 value (multiplier / divisor)
- Flush  input  1  synchronous abort from the hazard unit (branch/jump flush of EX)
- StallReq  output  1  combinational: (Start & state==IDLE & ~Flush) | state==CALC
- Done  output  1  registered; high for exactly one cycle when MdOut is valid
- MdOut  output  32  result; holds its value until the next accepted Start

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE -> CALC on Start & ~Flush:
  - latch MdOp and sign flags;
  - latch |Operand1| and |Operand2| per signedness: MULH, DIV and REM treat both operands as signed; MULHSU treats only Operand1 as signed; all others are unsigned;
  - clear the 64-bit accumulator and the 5-bit iteration counter.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle, LSB first, into a 64-bit product.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first, with a 33-bit partial remainder.
- CALC -> DONE when the counter reaches 31 (after 32 CALC cycles). The counter does not wrap.
- DONE: register the sign-corrected result into MdOut, drive Done=1, then go to IDLE unconditionally.
- Sign correction:
  - product is negated if the signed operand signs differ;
  - quotient is negated if the dividend and divisor signs differ;
  - remainder takes the sign of the dividend.
- Result select: MUL -> product[31:0]; MULH/MULHSU/MULHU -> product[63:32]; DIV/DIVU -> quotient; REM/REMU -> remainder.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend, original signed value.
- Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Both special cases still take the full latency. Latency is uniform for every MdOp.
- Start while not IDLE is ignored; the operands are not re-latched.
- Flush in any state: next state IDLE. No Done is produced, and MdOut keeps its previous value.
- Flush wins over a simultaneous Start.
- Reset (asynchronous, any time including mid-CALC): state IDLE, counter 0, accumulator 0, Done 0, MdOut 0x00000000. StallReq therefore evaluates to 0 unless Start is asserted.

## Timing
- Start is sampled at edge E0.
- StallReq is high combinationally during the Start cycle and during all 32 CALC cycles (E0..E32).
- StallReq is low in the DONE cycle, so the pipeline advances at E33 and EX/MEM captures MdOut with Done=1.
- Done is high only between E32 and E33.
- Total latency: 33 cycles from the Start cycle to the result being captured.
- Back-to-back operation: a new Start is accepted no earlier than the cycle after DONE (E33). Minimum issue interval is 34 cycles.
- Operand1/Operand2/MdOp need only be valid in the Start cycle.
- Flush asserted at edge Ek during CALC: StallReq is low from Ek onward. A Start presented in the same cycle as that Flush is dropped.

## Test plan
- MUL 7 x 6 (MdOp=0): Start at E0 -> Done exactly at E32..E33, MdOut=0x0000002A; StallReq high 33 cycles, then low.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD (-3); REM -7 % 2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- DIV and REM by zero with Operand1=0x12345678 -> DIV 0xFFFFFFFF, REM 0x12345678.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0x00000000.
- Start DIVU, Flush at CALC cycle 10 -> StallReq low the next cycle, no Done, MdOut unchanged. A new Start the following cycle completes normally 33 cycles later.
- rst_n pulsed low mid-CALC (no clock edge) -> Done=0 and MdOut=0 immediately, state IDLE. A Start during busy is ignored, and the first result is unaffected.
